// File: rtl/tmds_capture_probe.sv
// tmds_capture_probe
//
// On-chip capture buffer for recovered TMDS symbol words, clocked in the RX
// pixel clock domain. An arm button edge puts the probe in ARMED; the first
// valid sample that coincides with the selected trigger is stored at address
// 0, and the following valid samples fill the buffer up to DEPTH words. Once
// DONE, the step and rewind buttons walk a read pointer through the buffer.
// The word at the read pointer is shown in full and as one LANE_W-wide slice
// suitable for driving board LEDs.
//
// Ports:
//   clk        pixel clock, rising edge
//   rst_n      asynchronous active-low reset
//   din        captured sample (three 10-bit TMDS channels by default)
//   din_vld    sample valid; invalid samples are neither stored nor counted
//   hsync      trigger source (trig_mode 3, rising edge)
//   vsync      trigger source (trig_mode 1, rising edge)
//   vde        trigger source (trig_mode 2, rising edge)
//   trig_mode  0 immediate, 1 vsync rise, 2 vde rise, 3 hsync rise
//   arm        asynchronous button, rising edge starts a capture
//   step       asynchronous button, rising edge advances rd_addr in DONE
//   rewind     asynchronous button, rising edge clears rd_addr in DONE
//   lane_sel   selects the LANE_W slice of rd_data shown on lane_out
//   rd_addr    current read address
//   rd_data    buffer word at rd_addr, one clock behind rd_addr
//   lane_out   selected slice of rd_data, zero beyond DATA_W
//   state      0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   done       high while in DONE

module tmds_capture_probe #(
    parameter int DATA_W = 30,
    parameter int ADDR_W = 10,
    parameter int LANE_W = 8,
    parameter int LSEL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              vde,
    input  logic [1:0]        trig_mode,
    input  logic              arm,
    input  logic              step,
    input  logic              rewind,
    input  logic [LSEL_W-1:0] lane_sel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [LANE_W-1:0] lane_out,
    output logic [1:0]        state,
    output logic              done
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int NUM_LANES = (DATA_W + LANE_W - 1) / LANE_W;
    localparam int PAD_W     = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Button conditioning. Each vector is {delay, sync2, sync1}; the edge
    // pulse is sync2 & ~delay, so a held button yields a single one-cycle
    // pulse and the action lands on the third edge that sees it high.
    logic [2:0] arm_sync_q, arm_sync_d;
    logic [2:0] step_sync_q, step_sync_d;
    logic [2:0] rew_sync_q, rew_sync_d;
    logic       arm_edge, step_edge, rew_edge;

    // Previous-cycle copies of {vde, vsync, hsync} for rise detection.
    logic [2:0] trig_hist_q, trig_hist_d;
    logic       trig_hit;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   rd_data_q;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_comb begin
        arm_sync_d  = {arm_sync_q[1:0], arm};
        step_sync_d = {step_sync_q[1:0], step};
        rew_sync_d  = {rew_sync_q[1:0], rewind};
        trig_hist_d = {vde, vsync, hsync};
    end

    assign arm_edge  = arm_sync_q[1]  & ~arm_sync_q[2];
    assign step_edge = step_sync_q[1] & ~step_sync_q[2];
    assign rew_edge  = rew_sync_q[1]  & ~rew_sync_q[2];

    // Rises compare the live input against last cycle's registered value,
    // so the sample arriving with the rising level is the one stored.
    always_comb begin
        trig_hit = 1'b0;
        unique case (trig_mode)
            2'd0: trig_hit = 1'b1;
            2'd1: trig_hit = vsync & ~trig_hist_q[1];
            2'd2: trig_hit = vde   & ~trig_hist_q[2];
            2'd3: trig_hit = hsync & ~trig_hist_q[0];
            default: trig_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_sync_q  <= '0;
            step_sync_q <= '0;
            rew_sync_q  <= '0;
            trig_hist_q <= '0;
        end else begin
            arm_sync_q  <= arm_sync_d;
            step_sync_q <= step_sync_d;
            rew_sync_q  <= rew_sync_d;
            trig_hist_q <= trig_hist_d;
        end
    end

    // Control FSM. Arm has priority over everything, including a trigger or
    // a step/rewind landing on the same edge.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_addr_d = rd_addr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;

        if (arm_edge) begin
            state_d   = S_ARMED;
            wr_ptr_d  = '0;
            rd_addr_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_ARMED: begin
                    // A trigger without a valid sample is dropped; the
                    // next trigger gets another chance.
                    if (din_vld && trig_hit) begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        wr_ptr_d  = ADDR_W'(1);
                        state_d   = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (din_vld) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        // Last slot written: pointer wraps to 0 naturally.
                        if (wr_ptr_q == '1) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rew_edge) begin
                        rd_addr_d = '0;
                    end else if (step_edge) begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Sample memory: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= din;
        end
    end

    // Registered read port; sees the old word when the same address is
    // written on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

    // Lane display: rd_data zero-padded to a whole number of lanes; any
    // lane_sel past the last lane shows zero.
    always_comb begin
        logic [PAD_W-1:0] rd_pad;
        logic [31:0]      sel_idx;
        rd_pad   = PAD_W'(rd_data_q);
        sel_idx  = 32'(lane_sel);
        lane_out = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel_idx == 32'(i)) begin
                lane_out = rd_pad[i*LANE_W +: LANE_W];
            end
        end
    end

    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;
    assign state   = state_q;
    assign done    = (state_q == S_DONE);

endmodule

// File: doc/tmds_capture_probe.md
Name: tmds_capture_probe

Overview:
- Parametrised on-chip capture buffer for recovered TMDS symbol data, running in the RX pixel clock domain.
- Arms on a button edge, waits for a selectable sync/video trigger, then records DEPTH consecutive valid samples.
- After capture, samples are stepped out one at a time. The selected sample is presented as a full word and as a selectable LED-width lane for board-level inspection.

Parameters:
- DATA_W, 30, width of one captured sample (three 10-bit TMDS channels).
- ADDR_W, 10, log2 of buffer depth; DEPTH = 2**ADDR_W.
- LANE_W, 8, width of the lane_out display slice.
- LSEL_W, 3, width of lane_sel.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W  sample data.
- din_vld  in  1  sample valid (PLL locked); samples with din_vld=0 are neither written nor counted.
- hsync  in  1  trigger source.
- vsync  in  1  trigger source.
- vde  in  1  trigger source.
- trig_mode  in  2  trigger select: 0 immediate, 1 vsync rise, 2 vde rise, 3 hsync rise.
- arm  in  1  asynchronous button; its rising edge starts a capture.
- step  in  1  asynchronous button; its rising edge advances the read address.
- rewind  in  1  asynchronous button; its rising edge sets the read address to 0.
- lane_sel  in  LSEL_W  selects which LANE_W slice of rd_data drives lane_out.
- rd_addr  out  ADDR_W  current read address.
- rd_data  out  DATA_W  buffer word at rd_addr.
- lane_out  out  LANE_W  selected slice of rd_data.
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, rd_addr=0, rd_data=0, lane_out=0, done=0. Sync/edge flops and trigger-history flops all reset to 0.
- Button inputs (arm, step, rewind):
  - Each passes through a 2-flop synchroniser plus a delay flop; edge = sync & ~delayed.
  - Action takes effect at the 3rd rising clk edge at which the input is sampled high.
  - A held button produces exactly one action.
- Trigger history: hsync, vsync and vde are registered every cycle regardless of state. A rise means current=1 and previous=0.
- State machine:
  - Any state, arm edge: state -> ARMED, wr_ptr=0, rd_addr=0, done=0.
  - ARMED:
    - If din_vld=1 and the trigger condition holds this cycle (mode 0: always), write din at address 0, set wr_ptr=1, go to CAPTURE.
    - A trigger with din_vld=0 is ignored; wait for the next trigger.
  - CAPTURE:
    - Each din_vld=1 cycle writes din at wr_ptr, then increments wr_ptr.
    - The write to address DEPTH-1 moves state to DONE the same edge; wr_ptr wraps to 0.
    - din_vld=0 cycles hold wr_ptr.
  - DONE:
    - step edge: rd_addr+1, wrapping from DEPTH-1 to 0.
    - rewind edge: rd_addr=0.
    - Step and rewind on the same edge: rewind wins.
  - IDLE, ARMED, CAPTURE: step and rewind are ignored.
  - Arm coinciding with step/rewind: arm wins.
  - Arm edge during CAPTURE aborts and restarts in ARMED; partial data is left but is not valid.
- Memory:
  - Single-port-write, registered-read inferred RAM, DEPTH x DATA_W.
  - rd_data = mem[rd_addr], registered, so it is valid 1 clk after rd_addr changes.
  - Read is outside DONE is permitted; contents are undefined until the first capture.
- Lane slice:
  - NUM_LANES = ceil(DATA_W/LANE_W).
  - lane_out = rd_data[lane_sel*LANE_W +: LANE_W]; the top lane is zero-padded above DATA_W.
  - lane_sel >= NUM_LANES gives 0.
  - lane_out is combinational from rd_data and lane_sel.
- Asserting rst_n low at any point returns all state to reset values immediately; memory contents are not cleared.

Test Plan:
- Reset mid-CAPTURE (rst_n low at wr_ptr=5): state=0, rd_addr=0, lane_out=0 asynchronously. After release, the FSM stays IDLE until an arm edge.
- trig_mode=0, ADDR_W=4, din = counter 0x100.., din_vld=1, arm pulsed: capture starts the first ARMED cycle; DONE after 16 writes; step x3 gives rd_addr=3, rd_data=0x103 one clk later.
- trig_mode=1, vsync rises while din_vld=0 and again while din_vld=1 with din=0x2AAAAAAA: the first rise is ignored; mem[0]=0x2AAAAAAA.
- din_vld toggled 1/0 during CAPTURE, ADDR_W=4: DONE only after 16 valid samples (about 32 clk); stored words are contiguous valid samples with no gaps.
- In DONE at rd_addr=15, step: rd_addr=0. Then step+rewind together: rd_addr=0. With lane_sel=3 and DATA_W=30, lane_out={2'b00, rd_data[29:24]}; lane_sel=5 gives 0x00.
- Arm held high for 100 clk during DONE: exactly one re-arm (state=1, done=0). Step pulses while ARMED leave rd_addr unchanged.
